// File: rtl/n2_ict_tag_arb_ctl.sv
// Instruction-cache tag-array port controller: arbitrates fetch lookups, L2 fill
// tag writes and a full-array invalidate sweep onto one registered _bf port.
module n2_ict_tag_arb_ctl #(
    parameter int unsigned FILL_MAX = 4,
    parameter logic [29:0] INV_TAG  = 30'h0
) (
    input  logic        l2clk,
    input  logic        rst,
    input  logic        tcu_array_wr_inhibit,
    input  logic        fet_rd_req,
    input  logic [5:0]  fet_rd_index,
    output logic        fet_rd_gnt,
    output logic        ict_rd_vld_f,
    input  logic        fil_req,
    input  logic [5:0]  fil_index,
    input  logic [2:0]  fil_way,
    input  logic [29:0] fil_tag,
    output logic        fil_gnt,
    input  logic        inv_all_req,
    output logic        inv_busy,
    output logic        inv_done,
    output logic [5:0]  agd_ic_index_bf,
    output logic [2:0]  agc_fill_wrway_bf,
    output logic [29:0] agd_ict_wrtag_bf,
    output logic        ftp_tg_rd_req_bf,
    output logic        ftp_tg_wr_req_bf,
    output logic        ftp_tg_clk_en
);

    localparam logic [3:0] FILL_LIMIT = 4'(FILL_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [8:0]  sweep_ptr;
    logic [3:0]  starve_cnt;
    logic        sweep_wr_p0;
    logic        fill_wr_p0;
    logic        rd_issue_p0;
    logic        starved;

    assign starved  = (starve_cnt == FILL_LIMIT);
    assign inv_busy = (state != IDLE);
    assign inv_done = (state == DONE);

    // Stage p0: arbitration and sweep next-state from current inputs and state
    always_comb begin
        sweep_wr_p0 = 1'b0;
        fill_wr_p0  = 1'b0;
        rd_issue_p0 = 1'b0;
        state_nxt   = state;
        if (state == SWEEP) begin
            sweep_wr_p0 = !tcu_array_wr_inhibit;
        end else begin
            fill_wr_p0  = fil_req && !tcu_array_wr_inhibit && (!fet_rd_req || starved);
            rd_issue_p0 = fet_rd_req && !fill_wr_p0;
        end
        case (state)
            IDLE:    if (inv_all_req) state_nxt = SWEEP;
            SWEEP:   if (sweep_wr_p0 && (sweep_ptr == 9'd511)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered array controls and grant pulses
    always_ff @(posedge l2clk) begin
        if (rst) begin
            state             <= IDLE;
            sweep_ptr         <= 9'd0;
            starve_cnt        <= 4'd0;
            fet_rd_gnt        <= 1'b0;
            ict_rd_vld_f      <= 1'b0;
            fil_gnt           <= 1'b0;
            agd_ic_index_bf   <= 6'd0;
            agc_fill_wrway_bf <= 3'd0;
            agd_ict_wrtag_bf  <= 30'd0;
            ftp_tg_rd_req_bf  <= 1'b0;
            ftp_tg_wr_req_bf  <= 1'b0;
            ftp_tg_clk_en     <= 1'b0;
        end else begin
            state            <= state_nxt;
            fet_rd_gnt       <= rd_issue_p0;
            ict_rd_vld_f     <= fet_rd_gnt;
            fil_gnt          <= fill_wr_p0;
            ftp_tg_rd_req_bf <= rd_issue_p0;
            ftp_tg_wr_req_bf <= sweep_wr_p0 | fill_wr_p0;
            ftp_tg_clk_en    <= rd_issue_p0 | sweep_wr_p0 | fill_wr_p0;

            if (sweep_wr_p0) begin
                sweep_ptr         <= sweep_ptr + 9'd1;
                agd_ic_index_bf   <= sweep_ptr[8:3];
                agc_fill_wrway_bf <= sweep_ptr[2:0];
                agd_ict_wrtag_bf  <= INV_TAG;
            end else if (fill_wr_p0) begin
                agd_ic_index_bf   <= fil_index;
                agc_fill_wrway_bf <= fil_way;
                agd_ict_wrtag_bf  <= fil_tag;
            end else if (rd_issue_p0) begin
                agd_ic_index_bf   <= fet_rd_index;
            end

            // Starvation count is frozen while the sweep owns the port
            if (state != SWEEP) begin
                if (!fil_req || fill_wr_p0)
                    starve_cnt <= 4'd0;
                else if (rd_issue_p0 && !starved)
                    starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_n2_ict_tag_arb_ctl.sv
// Directed bench for n2_ict_tag_arb_ctl: reset, read path, fill starvation,
// write inhibit, invalidate sweep with stall and reset abort.
module tb_n2_ict_tag_arb_ctl;

    localparam logic [29:0] TB_INV_TAG = 30'h15A5A5A5;

    logic        l2clk = 1'b0;
    logic        rst;
    logic        tcu_array_wr_inhibit;
    logic        fet_rd_req;
    logic [5:0]  fet_rd_index;
    logic        fet_rd_gnt;
    logic        ict_rd_vld_f;
    logic        fil_req;
    logic [5:0]  fil_index;
    logic [2:0]  fil_way;
    logic [29:0] fil_tag;
    logic        fil_gnt;
    logic        inv_all_req;
    logic        inv_busy;
    logic        inv_done;
    logic [5:0]  agd_ic_index_bf;
    logic [2:0]  agc_fill_wrway_bf;
    logic [29:0] agd_ict_wrtag_bf;
    logic        ftp_tg_rd_req_bf;
    logic        ftp_tg_wr_req_bf;
    logic        ftp_tg_clk_en;

    int n_cmp = 0;
    int n_bad = 0;

    n2_ict_tag_arb_ctl #(.FILL_MAX(4), .INV_TAG(TB_INV_TAG)) dut (
        .l2clk(l2clk), .rst(rst), .tcu_array_wr_inhibit(tcu_array_wr_inhibit),
        .fet_rd_req(fet_rd_req), .fet_rd_index(fet_rd_index), .fet_rd_gnt(fet_rd_gnt),
        .ict_rd_vld_f(ict_rd_vld_f), .fil_req(fil_req), .fil_index(fil_index),
        .fil_way(fil_way), .fil_tag(fil_tag), .fil_gnt(fil_gnt),
        .inv_all_req(inv_all_req), .inv_busy(inv_busy), .inv_done(inv_done),
        .agd_ic_index_bf(agd_ic_index_bf), .agc_fill_wrway_bf(agc_fill_wrway_bf),
        .agd_ict_wrtag_bf(agd_ict_wrtag_bf), .ftp_tg_rd_req_bf(ftp_tg_rd_req_bf),
        .ftp_tg_wr_req_bf(ftp_tg_wr_req_bf), .ftp_tg_clk_en(ftp_tg_clk_en)
    );

    always #5 l2clk = ~l2clk;

    task automatic tick();
        @(posedge l2clk);
        #1;
    endtask

    task automatic idle_inputs();
        tcu_array_wr_inhibit = 1'b0;
        fet_rd_req   = 1'b0;
        fet_rd_index = 6'd0;
        fil_req      = 1'b0;
        fil_index    = 6'd0;
        fil_way      = 3'd0;
        fil_tag      = 30'd0;
        inv_all_req  = 1'b0;
    endtask

    task automatic test_reset();
        logic [46:0] obs;
        rst = 1'b1;
        fil_req = 1'b1; fil_index = 6'd5; fil_way = 3'd3; fil_tag = 30'h1234567;
        fet_rd_req = 1'b1; fet_rd_index = 6'h11; inv_all_req = 1'b1;
        tick();
        tick();
        obs = {fet_rd_gnt, ict_rd_vld_f, fil_gnt, inv_busy, inv_done, agd_ic_index_bf,
               agc_fill_wrway_bf, agd_ict_wrtag_bf, ftp_tg_rd_req_bf, ftp_tg_wr_req_bf, ftp_tg_clk_en};
        n_cmp++;
        if (obs !== 47'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        inv_all_req = 1'b0;
        rst = 1'b0;
        tick();
        // Starvation count is 0 after reset, so the read wins over the fill
        obs = {44'd0, fet_rd_gnt, fil_gnt, ftp_tg_rd_req_bf};
        n_cmp++;
        if (obs !== 47'b101 || agd_ic_index_bf !== 6'h11) begin
            n_bad++;
            $display("FAIL reset_first_grant: rd_gnt=%b fil_gnt=%b rd_bf=%b idx=%h want 1 0 1 11",
                     fet_rd_gnt, fil_gnt, ftp_tg_rd_req_bf, agd_ic_index_bf);
        end
        n_cmp++;
        if (inv_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_no_sweep: inv_busy=%b want 0", inv_busy);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_read_alone();
        fet_rd_req = 1'b1; fet_rd_index = 6'h2A;
        tick();
        fet_rd_req = 1'b0;
        n_cmp++;
        if ({ftp_tg_rd_req_bf, ftp_tg_wr_req_bf, ftp_tg_clk_en, fet_rd_gnt, agd_ic_index_bf} !== {4'b1011, 6'h2A}) begin
            n_bad++;
            $display("FAIL read_issue: rd=%b wr=%b en=%b gnt=%b idx=%h want 1 0 1 1 2a",
                     ftp_tg_rd_req_bf, ftp_tg_wr_req_bf, ftp_tg_clk_en, fet_rd_gnt, agd_ic_index_bf);
        end
        n_cmp++;
        if (ict_rd_vld_f !== 1'b0) begin
            n_bad++;
            $display("FAIL read_vld_early: vld=%b want 0", ict_rd_vld_f);
        end
        tick();
        n_cmp++;
        if ({ict_rd_vld_f, ftp_tg_rd_req_bf, ftp_tg_clk_en, fet_rd_gnt, agd_ic_index_bf} !== {4'b1000, 6'h2A}) begin
            n_bad++;
            $display("FAIL read_vld: vld=%b rd=%b en=%b gnt=%b idx=%h want 1 0 0 0 2a",
                     ict_rd_vld_f, ftp_tg_rd_req_bf, ftp_tg_clk_en, fet_rd_gnt, agd_ic_index_bf);
        end
        tick();
    endtask

    task automatic test_fill_starvation();
        fil_req = 1'b1; fil_index = 6'd5; fil_way = 3'd3; fil_tag = 30'h1234567;
        fet_rd_req = 1'b1; fet_rd_index = 6'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({fet_rd_gnt, fil_gnt, ftp_tg_wr_req_bf} !== 3'b100) begin
                n_bad++;
                $display("FAIL starve_read_%0d: rd_gnt=%b fil_gnt=%b wr=%b want 1 0 0",
                         i, fet_rd_gnt, fil_gnt, ftp_tg_wr_req_bf);
            end
        end
        tick();
        fil_req = 1'b0;
        n_cmp++;
        if ({fil_gnt, ftp_tg_wr_req_bf, ftp_tg_rd_req_bf, fet_rd_gnt, agc_fill_wrway_bf, agd_ict_wrtag_bf, agd_ic_index_bf}
            !== {4'b1100, 3'd3, 30'h1234567, 6'd5}) begin
            n_bad++;
            $display("FAIL starve_fill: gnt=%b wr=%b rd=%b rgnt=%b way=%0d tag=%h idx=%0d want 1 1 0 0 3 1234567 5",
                     fil_gnt, ftp_tg_wr_req_bf, ftp_tg_rd_req_bf, fet_rd_gnt, agc_fill_wrway_bf,
                     agd_ict_wrtag_bf, agd_ic_index_bf);
        end
        tick();
        fet_rd_req = 1'b0;
        n_cmp++;
        if ({fet_rd_gnt, fil_gnt, ftp_tg_wr_req_bf, agc_fill_wrway_bf, agd_ict_wrtag_bf, agd_ic_index_bf}
            !== {3'b100, 3'd3, 30'h1234567, 6'h10}) begin
            n_bad++;
            $display("FAIL starve_resume: rgnt=%b fgnt=%b wr=%b way=%0d tag=%h idx=%h want 1 0 0 3 1234567 10",
                     fet_rd_gnt, fil_gnt, ftp_tg_wr_req_bf, agc_fill_wrway_bf, agd_ict_wrtag_bf, agd_ic_index_bf);
        end
        tick();
    endtask

    task automatic test_inhibit();
        tcu_array_wr_inhibit = 1'b1;
        fil_req = 1'b1; fil_index = 6'd9; fil_way = 3'd6; fil_tag = 30'h2AAAAAAA;
        for (int i = 0; i < 5; i++) begin
            fet_rd_req   = (i == 2);
            fet_rd_index = 6'h33;
            tick();
            n_cmp++;
            if ({ftp_tg_wr_req_bf, fil_gnt} !== 2'b00) begin
                n_bad++;
                $display("FAIL inhibit_nowrite_%0d: wr=%b fil_gnt=%b want 0 0", i, ftp_tg_wr_req_bf, fil_gnt);
            end
            if (i == 2) begin
                n_cmp++;
                if ({fet_rd_gnt, ftp_tg_rd_req_bf, agd_ic_index_bf} !== {2'b11, 6'h33}) begin
                    n_bad++;
                    $display("FAIL inhibit_read: gnt=%b rd=%b idx=%h want 1 1 33",
                             fet_rd_gnt, ftp_tg_rd_req_bf, agd_ic_index_bf);
                end
            end
        end
        fet_rd_req = 1'b0;
        tcu_array_wr_inhibit = 1'b0;
        tick();
        fil_req = 1'b0;
        n_cmp++;
        if ({fil_gnt, ftp_tg_wr_req_bf, agc_fill_wrway_bf, agd_ict_wrtag_bf, agd_ic_index_bf}
            !== {2'b11, 3'd6, 30'h2AAAAAAA, 6'd9}) begin
            n_bad++;
            $display("FAIL inhibit_release: gnt=%b wr=%b way=%0d tag=%h idx=%0d want 1 1 6 2aaaaaaa 9",
                     fil_gnt, ftp_tg_wr_req_bf, agc_fill_wrway_bf, agd_ict_wrtag_bf, agd_ic_index_bf);
        end
        tick();
        n_cmp++;
        if ({fil_gnt, ftp_tg_wr_req_bf} !== 2'b00) begin
            n_bad++;
            $display("FAIL inhibit_single: gnt=%b wr=%b want 0 0", fil_gnt, ftp_tg_wr_req_bf);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [44:0] obs;
        logic [44:0] exp;
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        fil_req = 1'b1; fil_index = 6'd1; fil_way = 3'd1; fil_tag = 30'h7;
        fet_rd_req = 1'b1; fet_rd_index = 6'h3F;
        n_cmp++;
        if ({inv_busy, inv_done, ftp_tg_wr_req_bf} !== 3'b100) begin
            n_bad++;
            $display("FAIL sweep_start: busy=%b done=%b wr=%b want 1 0 0", inv_busy, inv_done, ftp_tg_wr_req_bf);
        end
        for (int k = 0; k < 512; k++) begin
            tick();
            obs = {ftp_tg_wr_req_bf, ftp_tg_rd_req_bf, fet_rd_gnt, fil_gnt, inv_busy, inv_done,
                   agd_ic_index_bf, agc_fill_wrway_bf, agd_ict_wrtag_bf};
            exp = {5'b10001, (k == 511), 6'(k / 8), 3'(k % 8), TB_INV_TAG};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL sweep_entry_%0d: got %h want %h", k, obs, exp);
            end
        end
        tick();
        fil_req = 1'b0; fet_rd_req = 1'b0;
        n_cmp++;
        if ({inv_busy, inv_done, ftp_tg_wr_req_bf, fet_rd_gnt, fil_gnt} !== 5'b00010) begin
            n_bad++;
            $display("FAIL sweep_end: busy=%b done=%b wr=%b rgnt=%b fgnt=%b want 0 0 0 1 0",
                     inv_busy, inv_done, ftp_tg_wr_req_bf, fet_rd_gnt, fil_gnt);
        end
        tick();
        tick();
    endtask

    task automatic test_sweep_inhibit();
        logic [42:0] obs;
        logic [42:0] exp;
        int k;
        logic [5:0] last_idx;
        logic [2:0] last_way;
        logic       wr_exp;
        k = 0; last_idx = agd_ic_index_bf; last_way = agc_fill_wrway_bf;
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        for (int c = 1; c <= 522; c++) begin
            tick();
            wr_exp = !(c >= 101 && c <= 110);
            if (wr_exp) begin
                last_idx = 6'(k / 8);
                last_way = 3'(k % 8);
                k++;
            end
            obs = {ftp_tg_wr_req_bf, ftp_tg_clk_en, inv_busy, inv_done, agd_ic_index_bf,
                   agc_fill_wrway_bf, agd_ict_wrtag_bf};
            exp = {wr_exp, wr_exp, 1'b1, (c == 522), last_idx, last_way, TB_INV_TAG};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL stall_cycle_%0d: got %h want %h", c, obs, exp);
            end
            if (c == 100) tcu_array_wr_inhibit = 1'b1;
            if (c == 110) tcu_array_wr_inhibit = 1'b0;
        end
        tick();
        n_cmp++;
        if ({inv_busy, inv_done, ftp_tg_wr_req_bf} !== 3'b000) begin
            n_bad++;
            $display("FAIL stall_end: busy=%b done=%b wr=%b want 0 0 0", inv_busy, inv_done, ftp_tg_wr_req_bf);
        end
    endtask

    task automatic test_sweep_reset();
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        for (int i = 0; i < 50; i++) tick();
        n_cmp++;
        if ({inv_busy, ftp_tg_wr_req_bf, agd_ic_index_bf, agc_fill_wrway_bf} !== {2'b11, 6'd6, 3'd1}) begin
            n_bad++;
            $display("FAIL abort_midwalk: busy=%b wr=%b idx=%0d way=%0d want 1 1 6 1",
                     inv_busy, ftp_tg_wr_req_bf, agd_ic_index_bf, agc_fill_wrway_bf);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({inv_busy, inv_done, ftp_tg_wr_req_bf, agd_ic_index_bf, agc_fill_wrway_bf} !== 12'd0) begin
            n_bad++;
            $display("FAIL abort_reset: busy=%b done=%b wr=%b idx=%0d way=%0d want all 0",
                     inv_busy, inv_done, ftp_tg_wr_req_bf, agd_ic_index_bf, agc_fill_wrway_bf);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({inv_busy, inv_done, ftp_tg_wr_req_bf} !== 3'b000) begin
                n_bad++;
                $display("FAIL abort_quiet_%0d: busy=%b done=%b wr=%b want 0 0 0",
                         i, inv_busy, inv_done, ftp_tg_wr_req_bf);
            end
        end
        // A new sweep must restart from entry 0
        inv_all_req = 1'b1;
        tick();
        inv_all_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ftp_tg_wr_req_bf, agd_ic_index_bf, agc_fill_wrway_bf} !== {1'b1, 6'd0, 3'd1}) begin
            n_bad++;
            $display("FAIL abort_restart: wr=%b idx=%0d way=%0d want 1 0 1",
                     ftp_tg_wr_req_bf, agd_ic_index_bf, agc_fill_wrway_bf);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_read_alone();
        test_fill_starvation();
        test_inhibit();
        test_sweep();
        test_sweep_inhibit();
        test_sweep_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
